reg_rd_port: RTL and testbench

Read-side port controller for the core register file: the consumer end of the `reg_rw` register bank. It accepts read requests over a valid/ready handshake and selects the addressed register from the bank's flattened outputs. It returns the data through a 2-entry response buffer with valid/ack backpressure and one-cycle latency. It sits between the register bank and the issue/CSR logic, with optional write-forwarding from the bank's write port.

---
 rtl/reg_rd_pkg.sv | 30 +++
 rtl/reg_rd_fifo2.sv | 78 +++++++
 rtl/reg_rd_port.sv | 99 +++++++++
 tb/tb_reg_rd_port.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_rd_pkg.sv
// Shared definitions for the register-file read port: default geometry,
// response entry layout and the response buffer occupancy states.
package reg_rd_pkg;

  // Default geometry of the core register bank
  localparam int DEF_XLEN   = 32;
  localparam int DEF_NREG   = 32;
  localparam int DEF_AWIDTH = 5;

  // One buffered response: error flag above the data word
  typedef struct packed {
    logic                err;
    logic [DEF_XLEN-1:0] data;
  } rd_entry_t;

  localparam int ENTRY_W = $bits(rd_entry_t);

  // Occupancy of the 2-entry response buffer; the encoding doubles as the count
  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_t;

  // Width of a response entry for an arbitrary data width
  function automatic int entry_width(input int xlen);
    return xlen + 1;
  endfunction

endpackage

// File: rtl/reg_rd_fifo2.sv
// Two-entry response buffer for the register read port. Wrapping 1-bit
// pointers, occupancy kept as an enum state. The head entry is always
// visible on 'head'; entries are not cleared on pop.
module reg_rd_fifo2
  import reg_rd_pkg::*;
#(
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_entry,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  fifo_state_t      state_q;
  fifo_state_t      state_d;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [WIDTH-1:0] mem [2];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (state_q == FIFO_FULL);
  assign empty   = (state_q == FIFO_EMPTY);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Occupancy register; reset empties the buffer immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FIFO_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy: a simultaneous push and pop leaves it unchanged
  always_comb begin
    state_d = state_q;
    case (state_q)
      FIFO_EMPTY: begin
        if (push_ok) state_d = FIFO_ONE;
      end
      FIFO_ONE: begin
        if (push_ok && !pop_ok)      state_d = FIFO_FULL;
        else if (!push_ok && pop_ok) state_d = FIFO_EMPTY;
      end
      FIFO_FULL: begin
        if (pop_ok && !push_ok) state_d = FIFO_ONE;
      end
      default: state_d = FIFO_EMPTY;
    endcase
  end

  // Pointers and storage; both pointers advance independently on push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

endmodule

// File: rtl/reg_rd_port.sv
// Read-side port of the core register bank. Accepts read requests over a
// valid/ready handshake, selects the addressed register (register 0 reads
// as zero, out-of-range addresses flag an error) and returns the result
// through a 2-entry buffer with one-cycle latency.
// Optional feature: define REG_RD_BYPASS_EN to forward a same-edge bank
// write to a read of the same register.
module reg_rd_port
  import reg_rd_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREG   = DEF_NREG,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_req,
  input  logic [AWIDTH-1:0]    rd_addr,
  output logic                 rd_rdy,
  input  logic [XLEN*NREG-1:0] regs_flat,
  input  logic                 wenble,
  input  logic [AWIDTH-1:0]    waddr,
  input  logic [XLEN-1:0]      wdata,
  output logic                 rd_vld,
  output logic [XLEN-1:0]      rd_data,
  output logic                 rd_err,
  input  logic                 rd_ack
);

  localparam int EW = entry_width(XLEN);
  localparam logic [AWIDTH:0] NREG_EXT = (AWIDTH+1)'(NREG);

  logic            addr_illegal;
  logic            addr_zero;
  logic            bypass_hit;
  logic [XLEN-1:0] reg_val;
  logic [XLEN-1:0] sel_data;
  logic            sel_err;
  logic            accept;
  logic            fifo_full;
  logic            fifo_empty;
  logic [EW-1:0]   head;

  assign addr_illegal = ({1'b0, rd_addr} >= NREG_EXT);
  assign addr_zero    = (rd_addr == '0);

`ifdef REG_RD_BYPASS_EN
  assign bypass_hit = wenble && (waddr == rd_addr) && !addr_zero && !addr_illegal;
`else
  logic unused_snoop;
  assign bypass_hit   = 1'b0;
  assign unused_snoop = ^{wenble, waddr, wdata};
`endif

  // Pick the addressed register out of the flattened bank contents
  always_comb begin
    reg_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_addr == AWIDTH'(i)) begin
        reg_val = regs_flat[i*XLEN +: XLEN];
      end
    end
  end

  // Response select: range error, hardwired zero, forwarded write, bank value
  always_comb begin
    sel_err  = 1'b0;
    sel_data = '0;
    if (addr_illegal) begin
      sel_err = 1'b1;
    end else if (addr_zero) begin
      sel_data = '0;
    end else if (bypass_hit) begin
      sel_data = wdata;
    end else begin
      sel_data = reg_val;
    end
  end

  assign accept = rd_req && rd_rdy;
  assign rd_rdy = !fifo_full;
  assign rd_vld = !fifo_empty;

  reg_rd_fifo2 #(
    .WIDTH(EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_entry({sel_err, sel_data}),
    .pop       (rd_ack),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd_err  = head[EW-1];
  assign rd_data = head[XLEN-1:0];

endmodule

// File: tb/tb_reg_rd_port.sv
// Scoreboard bench for reg_rd_port (built with NREG=16 so that illegal
// addresses exist). Honours REG_RD_BYPASS_EN in its reference model.
module tb_reg_rd_port;

  localparam int XLEN   = 32;
  localparam int NREG   = 16;
  localparam int AWIDTH = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 rd_req = 1'b0;
  logic [AWIDTH-1:0]    rd_addr = '0;
  logic                 rd_rdy;
  logic [XLEN*NREG-1:0] regs_flat;
  logic                 wenble = 1'b0;
  logic [AWIDTH-1:0]    waddr = '0;
  logic [XLEN-1:0]      wdata = '0;
  logic                 rd_vld;
  logic [XLEN-1:0]      rd_data;
  logic                 rd_err;
  logic                 rd_ack = 1'b0;

  logic [XLEN-1:0] model_regs [NREG];
  logic [XLEN:0]   exp_q [$];
  int              checks = 0;
  int              errors = 0;

  reg_rd_port #(
    .XLEN  (XLEN),
    .NREG  (NREG),
    .AWIDTH(AWIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_rdy   (rd_rdy),
    .regs_flat(regs_flat),
    .wenble   (wenble),
    .waddr    (waddr),
    .wdata    (wdata),
    .rd_vld   (rd_vld),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .rd_ack   (rd_ack)
  );

  always #5 clk = ~clk;

  // The emulated register bank drives the flattened contents
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREG; i++) begin
      regs_flat[i*XLEN +: XLEN] = model_regs[i];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {err, data} for a read accepted alongside the given bank write
  function automatic logic [XLEN:0] refRead(input int addr, input logic we, input int wa,
                                            input logic [XLEN-1:0] wd);
    if (addr >= NREG) return {1'b1, {XLEN{1'b0}}};
    if (addr == 0) return '0;
`ifdef REG_RD_BYPASS_EN
    if (we && wa == addr) return {1'b0, wd};
`endif
    return {1'b0, model_regs[addr]};
  endfunction

  // One cycle of stimulus; the expected response is queued once the accept edge passes
  task automatic applyStimulus(input logic req, input logic [AWIDTH-1:0] addr, input logic ack,
                               input logic we, input logic [AWIDTH-1:0] wa,
                               input logic [XLEN-1:0] wd, output logic accepted);
    logic [XLEN:0] e;
    @(negedge clk);
    rd_req  = req;
    rd_addr = addr;
    rd_ack  = ack;
    wenble  = we;
    waddr   = wa;
    wdata   = wd;
    #1;
    accepted = req && rd_rdy;
    e = refRead(int'(addr), we, int'(wa), wd);
    @(posedge clk);
    #1;
    if (accepted) exp_q.push_back(e);
    if (we && wa != 0 && int'(wa) < NREG) model_regs[wa] = wd;
  endtask

  task automatic idle(input int n, input logic ack);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, ack, 1'b0, '0, '0, acc);
  endtask

  // Hold a request until it is accepted, within a bounded number of cycles
  task automatic issueRead(input logic [AWIDTH-1:0] addr, input logic ack);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 16) begin
      applyStimulus(1'b1, addr, ack, 1'b0, '0, '0, acc);
      n++;
    end
    checkOutput("request accepted within budget", acc, 1);
  endtask

  // Monitor: compares handshake flags with scoreboard occupancy and pops on each response taken
  always begin
    logic [XLEN:0] e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      checkOutput("rd_vld", rd_vld, exp_q.size() != 0);
      checkOutput("rd_rdy", rd_rdy, exp_q.size() < 2);
      if (rd_vld && rd_ack) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected response", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rd_data", rd_data, e[XLEN-1:0]);
          checkOutput("rd_err", rd_err, e[XLEN]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic            acc;
    logic            pend;
    logic [AWIDTH-1:0] paddr;
    logic            we;
    logic [AWIDTH-1:0] wa;

    for (int i = 0; i < NREG; i++) model_regs[i] = $urandom;
    model_regs[0] = 32'hFFFF_FFFF;
    model_regs[3] = 32'hDEAD_BEEF;

    #1;
    checkOutput("reset rd_vld", rd_vld, 0);
    checkOutput("reset rd_rdy", rd_rdy, 1);
    checkOutput("reset rd_data", rd_data, 0);
    checkOutput("reset rd_err", rd_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First read: register 3
    applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, '0, '0, acc);
    checkOutput("first accept", acc, 1);
    idle(2, 1'b1);

    // Hardwired zero and out-of-range address
    issueRead(5'd0, 1'b1);
    issueRead(5'd20, 1'b1);
    idle(2, 1'b1);

    // Backpressure: third request held until a pop frees a slot
    applyStimulus(1'b1, 5'd1, 1'b0, 1'b0, '0, '0, acc);
    checkOutput("bp accept addr1", acc, 1);
    applyStimulus(1'b1, 5'd2, 1'b0, 1'b0, '0, '0, acc);
    checkOutput("bp accept addr2", acc, 1);
    applyStimulus(1'b1, 5'd3, 1'b0, 1'b0, '0, '0, acc);
    checkOutput("bp addr3 held when full", acc, 0);
    applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, '0, '0, acc);
    checkOutput("bp no same-cycle refill", acc, 0);
    applyStimulus(1'b1, 5'd3, 1'b0, 1'b0, '0, '0, acc);
    checkOutput("bp addr3 accepted after pop", acc, 1);
    idle(3, 1'b1);

    // Streaming: eight back-to-back reads with ack held high
    for (int a = 1; a <= 8; a++) begin
      applyStimulus(1'b1, AWIDTH'(a), 1'b1, 1'b0, '0, '0, acc);
      checkOutput("stream accept", acc, 1);
    end
    idle(2, 1'b1);

    // Same-edge write and read of register 5, then of register 0
    model_regs[5] = 32'h11;
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 32'h22, acc);
    checkOutput("bypass accept", acc, 1);
    applyStimulus(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 32'h33, acc);
    checkOutput("zero write accept", acc, 1);
    idle(2, 1'b1);

    // Asynchronous reset while the buffer is full
    applyStimulus(1'b1, 5'd6, 1'b0, 1'b0, '0, '0, acc);
    applyStimulus(1'b1, 5'd7, 1'b0, 1'b0, '0, '0, acc);
    idle(1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset rd_vld", rd_vld, 0);
    checkOutput("async reset rd_rdy", rd_rdy, 1);
    checkOutput("async reset rd_data", rd_data, 0);
    checkOutput("async reset rd_err", rd_err, 0);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    idle(3, 1'b1);

    // Randomised traffic: requests held until accepted, random acks and bank writes
    pend  = 1'b0;
    paddr = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend && ($urandom_range(0, 2) != 0)) begin
        pend  = 1'b1;
        paddr = AWIDTH'($urandom_range(0, 23));
      end
      we = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 1) == 1) ? paddr : AWIDTH'($urandom_range(0, 23));
      applyStimulus(pend, paddr, ($urandom_range(0, 3) != 0), we, wa, $urandom, acc);
      if (acc) pend = 1'b0;
    end
    idle(4, 1'b1);
    checkOutput("scoreboard drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
